hilo_register_unit: RTL and testbench
=====================================

// Module: hilo_register_unit
// PURPOSE
// - Owns the architectural HI/LO register pair on the write side of the ALU HI/LO interface.
// - Accepts HI_out/LO_out writes from the EX stage (mult, multu, madd, msub, mthi, mtlo).
// - Carries each write through COMMIT_STAGES internal stages that mirror EX/MEM and MEM/WB.
// - Returns forwarded HI/LO values to the ALU HI_in/LO_in, so back-to-back HI/LO instructions need no stall.
// PARAMETERS
// WIDTH          32  data width of HI and LO
// COMMIT_STAGES  2   in-flight stages before commit; legal range 1..4
// CNT_W          16  width of CommitCount
// PORTS
// Clk          in   1      clock, rising edge
// Reset        in   1      asynchronous, active-high reset
// WrEnHI       in   1      EX-stage write of HI this cycle
// WrEnLO       in   1      EX-stage write of LO this cycle
// HI_wr        in   WIDTH  HI write data (ALU HI_out)
// LO_wr        in   WIDTH  LO write data (ALU LO_out)
// Stall        in   1      freeze all stages and the architectural registers
// Flush        in   1      squash the youngest in-flight entry and the incoming write
// HI_rd        out  WIDTH  forwarded HI value; drives ALU HI_in
// LO_rd        out  WIDTH  forwarded LO value; drives ALU LO_in
// HI_arch      out  WIDTH  committed HI
// LO_arch      out  WIDTH  committed LO
// Pending      out  1      high when any stage holds a valid HI or LO entry
// CommitCount  out  CNT_W  number of committed entries; wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset:
//   - All outputs and stage data clear to 0 immediately (asynchronous).
//   - All stage valid bits clear to 0.
//   - Reset asserted mid-operation discards every in-flight write; nothing commits.
// - Stage s (0 = youngest) holds vHI[s], vLO[s], dHI[s], dLO[s].
//   - An entry is valid when vHI[s] | vLO[s].
// - Rising edge with Stall=0 and Flush=0:
//   - Stage 0 takes {WrEnHI, WrEnLO, HI_wr, LO_wr}.
//   - Stage s takes stage s-1.
//   - The last stage retires:
//     - vHI set: HI_arch <= dHI.
//     - vLO set: LO_arch <= dLO.
//     - Entry valid: CommitCount increments by 1.
// - Rising edge with Stall=1 and Flush=0:
//   - All stages, the architectural registers and CommitCount hold.
//   - The incoming write is dropped. The hazard unit must not raise Stall across a live EX write.
// - Rising edge with Flush=1:
//   - The current stage-0 entry is discarded.
//   - The incoming write is not captured.
//   - When Stall=0: stages advance normally from stage 1 onward and stage 0 becomes invalid.
//   - When Stall=1: only stage 0 clears; everything else holds.
//   - Flush has priority over Stall for stage 0 only.
// - Write latency:
//   - A write presented before edge t is in stage 0 after edge t.
//   - It is architectural after edge t+COMMIT_STAGES-1 (no stalls).
// - Read path (combinational, no dependence on the WrEn*/HI_wr/LO_wr inputs, so there is no loop through the ALU):
//   - HI_rd = dHI of the youngest stage with vHI=1, else HI_arch.
//   - LO_rd is resolved the same way, independently of HI_rd.
//   - An entry with only WrEnLO set does not shadow an older HI write.
// - Pending = OR of the valid bits across all stages.
// - CommitCount wraps from 2^CNT_W-1 to 0 with no flag.
// - WrEnHI=WrEnLO=0 creates an invalid bubble entry: it shifts but commits nothing and does not count.
// TESTING
// - T1 reset: HI_wr=1234 and WrEnHI=1 are captured, then Reset pulses for half a cycle
//   -> all outputs 0, Pending=0, no commit.
// - T2 forwarding: mthi 0xDEADBEEF at edge 1
//   -> HI_rd=0xDEADBEEF during cycle 2;
//   -> HI_arch=0xDEADBEEF after edge 2 (COMMIT_STAGES=2); CommitCount=1.
// - T3 partial write: mtlo 5 then mthi 7 on consecutive cycles
//   -> HI_rd=7 and LO_rd=5 next cycle; after drain, arch = {7,5}, CommitCount=2.
// - T4 madd chain: HI/LO={0,10}, then three madd with A=2, B=3 back-to-back, ALU fed from HI_rd/LO_rd
//   -> LO_arch=28, HI_arch=0.
// - T5 flush: mthi 9 at edge 1, mthi 4 at edge 2, Flush=1 at edge 3
//   -> the 4 is squashed, HI_arch=9, CommitCount=1.
// - T6 stall/wrap: CNT_W=2, commit 5 writes with Stall=1 for 3 cycles midway
//   -> no retirement while stalled; CommitCount reads 1 at the end.

Source files
------------

// File: rtl/hilo_register_unit_if.sv
// Write-side HI/LO bus between the EX stage and the HI/LO register unit.
// The master drives the EX writes and pipeline control; the slave returns the forwarded and committed values.
interface hilo_register_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             wr_en_hi;
  logic             wr_en_lo;
  logic [WIDTH-1:0] hi_wr;
  logic [WIDTH-1:0] lo_wr;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] hi_rd;
  logic [WIDTH-1:0] lo_rd;
  logic [WIDTH-1:0] hi_arch;
  logic [WIDTH-1:0] lo_arch;
  logic             pending;
  logic [CNT_W-1:0] commit_count;

  modport master (
    output wr_en_hi, wr_en_lo, hi_wr, lo_wr, stall, flush,
    input  hi_rd, lo_rd, hi_arch, lo_arch, pending, commit_count
  );

  modport slave (
    input  wr_en_hi, wr_en_lo, hi_wr, lo_wr, stall, flush,
    output hi_rd, lo_rd, hi_arch, lo_arch, pending, commit_count
  );
endinterface

// File: rtl/hilo_register_unit.sv
// Architectural HI/LO pair with COMMIT_STAGES in-flight stages and youngest-first forwarding.
// An entry becomes architectural on the edge it enters the last stage.
module hilo_register_unit #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned COMMIT_STAGES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input logic                 clk,
  input logic                 rst,
  hilo_register_unit_if.slave bus
);
  localparam int unsigned N = COMMIT_STAGES;

  typedef struct packed {
    logic             v_hi;
    logic             v_lo;
    logic [WIDTH-1:0] d_hi;
    logic [WIDTH-1:0] d_lo;
  } stage_t;

  stage_t           stg [N];
  stage_t           nxt [N];
  stage_t           incoming;
  logic             commit_c;
  logic [WIDTH-1:0] hi_arch;
  logic [WIDTH-1:0] lo_arch;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi_fwd;
  logic [WIDTH-1:0] lo_fwd;
  logic             any_valid;

  // Next stage contents: flush kills stage 0 regardless of stall, stall freezes the rest.
  always_comb begin
    incoming = '{v_hi: bus.wr_en_hi, v_lo: bus.wr_en_lo, d_hi: bus.hi_wr, d_lo: bus.lo_wr};
    for (int s = 0; s < int'(N); s++) nxt[s] = stg[s];
    if (bus.flush)
      nxt[0] = '0;
    else if (!bus.stall)
      nxt[0] = incoming;
    if (!bus.stall) begin
      for (int s = 1; s < int'(N); s++)
        nxt[s] = (s == 1 && bus.flush) ? stage_t'('0) : stg[s-1];
    end
    commit_c = !bus.stall && (nxt[N-1].v_hi || nxt[N-1].v_lo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(N); s++) stg[s] <= '0;
      hi_arch <= '0;
      lo_arch <= '0;
      count   <= '0;
    end else begin
      for (int s = 0; s < int'(N); s++) stg[s] <= nxt[s];
      if (commit_c) begin
        if (nxt[N-1].v_hi) hi_arch <= nxt[N-1].d_hi;
        if (nxt[N-1].v_lo) lo_arch <= nxt[N-1].d_lo;
        count <= count + CNT_W'(1);
      end
    end
  end

  // Forwarding looks only at stored state, so there is no path from the write inputs.
  always_comb begin
    logic hi_found;
    logic lo_found;
    hi_fwd    = hi_arch;
    lo_fwd    = lo_arch;
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    any_valid = 1'b0;
    for (int s = 0; s < int'(N); s++) begin
      if (!hi_found && stg[s].v_hi) begin
        hi_fwd   = stg[s].d_hi;
        hi_found = 1'b1;
      end
      if (!lo_found && stg[s].v_lo) begin
        lo_fwd   = stg[s].d_lo;
        lo_found = 1'b1;
      end
      any_valid = any_valid | stg[s].v_hi | stg[s].v_lo;
    end
  end

  assign bus.hi_rd        = hi_fwd;
  assign bus.lo_rd        = lo_fwd;
  assign bus.hi_arch      = hi_arch;
  assign bus.lo_arch      = lo_arch;
  assign bus.pending      = any_valid;
  assign bus.commit_count = count;
endmodule

// File: tb/tb_hilo_register_unit.sv
// Bench for hilo_register_unit: directed scenarios plus random traffic against an age-based queue model.
// Two instances share stimulus; the second has a 2-bit commit counter to exercise wrap.
module tb_hilo_register_unit;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  hilo_register_unit_if #(.WIDTH(32), .CNT_W(16)) ifa ();
  hilo_register_unit_if #(.WIDTH(32), .CNT_W(2))  ifb ();

  hilo_register_unit #(.WIDTH(32), .COMMIT_STAGES(N), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  hilo_register_unit #(.WIDTH(32), .COMMIT_STAGES(N), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Model: every accepted write ages by one per unstalled edge; it commits at age N-1, leaves at age N.
  typedef struct {
    logic        vh;
    logic        vl;
    logic [31:0] dh;
    logic [31:0] dl;
    int          age;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int unsigned m_cnt;

  task automatic model_reset();
    q.delete();
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic wh, wl, input logic [31:0] h, l, input logic st, fl);
    if (fl && q.size() > 0 && q[q.size()-1].age == 0) void'(q.pop_back());
    if (!st) begin
      foreach (q[i]) q[i].age++;
      if (!fl && (wh || wl)) q.push_back('{vh: wh, vl: wl, dh: h, dl: l, age: 0});
      foreach (q[i]) begin
        if (q[i].age == int'(N) - 1) begin
          if (q[i].vh) m_hi = q[i].dh;
          if (q[i].vl) m_lo = q[i].dl;
          m_cnt++;
        end
      end
      while (q.size() > 0 && q[0].age >= int'(N)) void'(q.pop_front());
    end
  endtask

  function automatic logic [31:0] mdl_hi_rd();
    logic [31:0] r = m_hi;
    foreach (q[i]) if (q[i].vh) r = q[i].dh;
    return r;
  endfunction

  function automatic logic [31:0] mdl_lo_rd();
    logic [31:0] r = m_lo;
    foreach (q[i]) if (q[i].vl) r = q[i].dl;
    return r;
  endfunction

  task automatic drive(input logic wh, wl, input logic [31:0] h, l, input logic st, fl);
    ifa.wr_en_hi = wh; ifa.wr_en_lo = wl; ifa.hi_wr = h; ifa.lo_wr = l; ifa.stall = st; ifa.flush = fl;
    ifb.wr_en_hi = wh; ifb.wr_en_lo = wl; ifb.hi_wr = h; ifb.lo_wr = l; ifb.stall = st; ifb.flush = fl;
  endtask

  // One clock: drive away from the edge, let the edge happen, update the model, settle.
  task automatic step(input logic wh, wl, input logic [31:0] h, l, input logic st, fl);
    drive(wh, wl, h, l, st, fl);
    @(posedge clk);
    model_edge(wh, wl, h, l, st, fl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, 1'b0, 32'd1234, '0, 1'b0, 1'b0);
    checks++; if (ifa.hi_rd !== 32'd1234) $display("FAIL t1_captured hi_rd got %0d exp 1234", ifa.hi_rd); else passed++;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    checks++; if ({ifa.hi_rd, ifa.lo_rd, ifa.hi_arch, ifa.lo_arch} !== 128'd0)
      $display("FAIL t1_async_data got %h/%h/%h/%h exp 0", ifa.hi_rd, ifa.lo_rd, ifa.hi_arch, ifa.lo_arch); else passed++;
    checks++; if (ifa.pending !== 1'b0 || ifa.commit_count !== 16'd0)
      $display("FAIL t1_async_ctrl pending %b count %0d exp 0/0", ifa.pending, ifa.commit_count); else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3);
    checks++; if (ifa.hi_arch !== 32'd0 || ifa.commit_count !== 16'd0 || ifa.pending !== 1'b0)
      $display("FAIL t1_no_commit hi_arch %0d count %0d pending %b exp 0/0/0", ifa.hi_arch, ifa.commit_count, ifa.pending); else passed++;
  endtask

  task automatic test_forwarding();
    do_reset();
    step(1'b1, 1'b0, 32'hDEADBEEF, '0, 1'b0, 1'b0);
    checks++; if (ifa.hi_rd !== 32'hDEADBEEF) $display("FAIL t2_fwd hi_rd got %h exp deadbeef", ifa.hi_rd); else passed++;
    checks++; if (ifa.hi_arch !== 32'd0 || ifa.pending !== 1'b1)
      $display("FAIL t2_not_yet hi_arch %h pending %b exp 0/1", ifa.hi_arch, ifa.pending); else passed++;
    idle(1);
    checks++; if (ifa.hi_arch !== 32'hDEADBEEF || ifa.commit_count !== 16'd1)
      $display("FAIL t2_commit hi_arch %h count %0d exp deadbeef/1", ifa.hi_arch, ifa.commit_count); else passed++;
  endtask

  task automatic test_partial();
    do_reset();
    step(1'b0, 1'b1, '0, 32'd5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd7, '0, 1'b0, 1'b0);
    checks++; if (ifa.hi_rd !== 32'd7 || ifa.lo_rd !== 32'd5)
      $display("FAIL t3_fwd hi_rd %0d lo_rd %0d exp 7/5", ifa.hi_rd, ifa.lo_rd); else passed++;
    idle(2);
    checks++; if (ifa.hi_arch !== 32'd7 || ifa.lo_arch !== 32'd5 || ifa.commit_count !== 16'd2 || ifa.pending !== 1'b0)
      $display("FAIL t3_drain arch %0d/%0d count %0d pending %b exp 7/5/2/0",
               ifa.hi_arch, ifa.lo_arch, ifa.commit_count, ifa.pending); else passed++;
  endtask

  task automatic test_madd();
    logic [63:0] acc;
    do_reset();
    step(1'b0, 1'b1, '0, 32'd10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      acc = {ifa.hi_rd, ifa.lo_rd} + 64'(2 * 3);
      step(1'b1, 1'b1, acc[63:32], acc[31:0], 1'b0, 1'b0);
    end
    checks++; if (ifa.lo_rd !== 32'd28) $display("FAIL t4_fwd lo_rd got %0d exp 28", ifa.lo_rd); else passed++;
    idle(2);
    checks++; if (ifa.lo_arch !== 32'd28 || ifa.hi_arch !== 32'd0 || ifa.commit_count !== 16'd4)
      $display("FAIL t4_arch lo %0d hi %0d count %0d exp 28/0/4", ifa.lo_arch, ifa.hi_arch, ifa.commit_count); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 1'b0, 32'd9, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd4, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd1, '0, 1'b0, 1'b1);
    checks++; if (ifa.hi_rd !== 32'd9) $display("FAIL t5_squash hi_rd got %0d exp 9", ifa.hi_rd); else passed++;
    idle(2);
    checks++; if (ifa.hi_arch !== 32'd9 || ifa.commit_count !== 16'd1 || ifa.pending !== 1'b0)
      $display("FAIL t5_arch hi %0d count %0d pending %b exp 9/1/0", ifa.hi_arch, ifa.commit_count, ifa.pending); else passed++;
  endtask

  task automatic test_stall_wrap();
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 32'(i), 32'(i + 100), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if (ifa.commit_count !== 16'd2 || ifb.commit_count !== 2'd2 || ifa.hi_arch !== 32'd2)
        $display("FAIL t6_stall_hold count %0d/%0d hi_arch %0d exp 2/2/2", ifa.commit_count, ifb.commit_count, ifa.hi_arch); else passed++;
    end
    for (int i = 4; i <= 5; i++) step(1'b1, 1'b1, 32'(i), 32'(i + 100), 1'b0, 1'b0);
    idle(2);
    checks++; if (ifb.commit_count !== 2'd1 || ifa.commit_count !== 16'd5)
      $display("FAIL t6_wrap count_b %0d count_a %0d exp 1/5", ifb.commit_count, ifa.commit_count); else passed++;
    checks++; if (ifa.hi_arch !== 32'd5 || ifa.lo_arch !== 32'd105)
      $display("FAIL t6_arch hi %0d lo %0d exp 5/105", ifa.hi_arch, ifa.lo_arch); else passed++;
  endtask

  task automatic test_random();
    logic        wh, wl, st, fl;
    logic [31:0] h, l;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wh = 1'($urandom_range(0, 1));
      wl = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      h  = $urandom;
      l  = $urandom;
      step(wh, wl, h, l, st, fl);
      checks++; if (ifa.hi_rd !== mdl_hi_rd() || ifa.lo_rd !== mdl_lo_rd())
        $display("FAIL rnd_fwd cyc %0d got %h/%h exp %h/%h", c, ifa.hi_rd, ifa.lo_rd, mdl_hi_rd(), mdl_lo_rd()); else passed++;
      checks++; if (ifa.hi_arch !== m_hi || ifa.lo_arch !== m_lo)
        $display("FAIL rnd_arch cyc %0d got %h/%h exp %h/%h", c, ifa.hi_arch, ifa.lo_arch, m_hi, m_lo); else passed++;
      checks++; if (ifa.pending !== (q.size() > 0) || ifa.commit_count !== 16'(m_cnt) || ifb.commit_count !== 2'(m_cnt))
        $display("FAIL rnd_ctrl cyc %0d pending %b count %0d/%0d exp %b/%0d",
                 c, ifa.pending, ifa.commit_count, ifb.commit_count, (q.size() > 0), m_cnt); else passed++;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_forwarding();
    test_partial();
    test_madd();
    test_flush();
    test_stall_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after 1000000 time units");
    $fatal(1);
  end
endmodule
